// File: rtl/wb_line_drain.sv
// Drains one cache line at a time from the write-back FIFO head into a single
// INCR write burst, and lets the cache controller ask whether a label is in flight.
module wb_line_drain #(
    parameter  int LINE_WIDTH  = 256,
    parameter  int DATA_WIDTH  = 32,
    localparam int BEATS       = LINE_WIDTH / DATA_WIDTH,
    localparam int OFFSET      = $clog2(LINE_WIDTH / 8),
    localparam int LABEL_WIDTH = 32 - OFFSET
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [LABEL_WIDTH+LINE_WIDTH-1:0] line,
    input  logic                              empty,
    output logic                              pop,
    input  logic [LABEL_WIDTH-1:0]            query_label,
    output logic                              query_inflight,
    output logic                              busy,
    output logic [31:0]                       awaddr,
    output logic [7:0]                        awlen,
    output logic [2:0]                        awsize,
    output logic [1:0]                        awburst,
    output logic                              awvalid,
    input  logic                              awready,
    output logic [DATA_WIDTH-1:0]             wdata,
    output logic [DATA_WIDTH/8-1:0]           wstrb,
    output logic                              wlast,
    output logic                              wvalid,
    input  logic                              wready,
    input  logic                              bvalid,
    output logic                              bready
);

    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                               state;
    logic [BEAT_W-1:0]                    beat;
    logic [BEATS-1:0][DATA_WIDTH-1:0]     buffer;
    logic [LABEL_WIDTH-1:0]               label;

    // The line is captured on the pop edge so the FIFO may move on immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            beat   <= '0;
            buffer <= '0;
            label  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        buffer <= line[LINE_WIDTH-1:0];
                        label  <= line[LINE_WIDTH +: LABEL_WIDTH];
                        state  <= ADDR;
                    end
                end
                ADDR: begin
                    if (awready) begin
                        beat  <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (wready) begin
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= RESP;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (bvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // All channel outputs are decoded from registered state, so they hold while stalled.
    assign pop            = (state == IDLE) && !empty && !rst;
    assign busy           = (state != IDLE);
    assign query_inflight = busy && (query_label == label);

    assign awvalid = (state == ADDR);
    assign awaddr  = {label, {OFFSET{1'b0}}};
    assign awlen   = 8'(BEATS - 1);
    assign awsize  = 3'($clog2(DATA_WIDTH / 8));
    assign awburst = 2'b01;

    assign wvalid  = (state == DATA);
    assign wdata   = buffer[beat];
    assign wstrb   = '1;
    assign wlast   = (state == DATA) && (beat == LAST_BEAT);

    assign bready  = (state == RESP);

endmodule

// File: tb/tb_wb_line_drain.sv
// Bench for wb_line_drain: a transaction-level FIFO/slave model scoreboards every
// cycle, driven by a vector table, directed corner sequences and random traffic.
module tb_wb_line_drain;

    localparam int LINE_WIDTH  = 256;
    localparam int DATA_WIDTH  = 32;
    localparam int BEATS       = 8;
    localparam int LABEL_WIDTH = 27;
    localparam int ENTRY_W     = LABEL_WIDTH + LINE_WIDTH;

    typedef logic [ENTRY_W-1:0] entry_t;

    typedef struct {
        logic [LABEL_WIDTH-1:0] label;
        logic [31:0]            base;
        int                     aw_delay;
        int                     w_gap;
        logic [31:0]            exp_addr;
        int                     exp_busy;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst;
    entry_t                 line;
    logic                   empty;
    logic                   pop;
    logic [LABEL_WIDTH-1:0] query_label;
    logic                   query_inflight;
    logic                   busy;
    logic [31:0]            awaddr;
    logic [7:0]             awlen;
    logic [2:0]             awsize;
    logic [1:0]             awburst;
    logic                   awvalid;
    logic                   awready;
    logic [DATA_WIDTH-1:0]  wdata;
    logic [3:0]             wstrb;
    logic                   wlast;
    logic                   wvalid;
    logic                   wready;
    logic                   bvalid;
    logic                   bready;

    wb_line_drain #(.LINE_WIDTH(LINE_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk(clk), .rst(rst), .line(line), .empty(empty), .pop(pop),
        .query_label(query_label), .query_inflight(query_inflight), .busy(busy),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: FIFO contents and progress of the line in flight.
    entry_t                 fifo_q[$];
    bit                     pop_seen = 0;
    bit                     in_flight = 0;
    bit                     aw_done = 0;
    int                     beats = 0;
    entry_t                 cur_line = '0;
    logic [LABEL_WIDTH-1:0] cur_label = '0;
    int                     lines_done = 0;
    int                     pop_count = 0;
    int                     busy_cycles = 0;
    int                     valid_cycles = 0;
    int                     pop_gap = 0;
    int                     last_b_cyc = 0;
    int                     cyc = 0;
    logic [31:0]            last_awaddr = '0;

    int aw_delay = 0, w_gap = 0, b_delay = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0;

    task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(entry_t e, int i);
        return e[i*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    function automatic entry_t make_line(logic [LABEL_WIDTH-1:0] lbl, logic [31:0] base);
        entry_t e = '0;
        for (int i = 0; i < BEATS; i++) e[i*DATA_WIDTH +: DATA_WIDTH] = base + 32'(i);
        e[ENTRY_W-1 -: LABEL_WIDTH] = lbl;
        return e;
    endfunction

    task automatic apply_stimulus(entry_t e);
        fifo_q.push_back(e);
    endtask

    task automatic wait_lines(int target, int budget);
        int n = 0;
        while (lines_done < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_output("lines_timeout", 64'(lines_done >= target), 64'd1);
    endtask

    always @(posedge clk) cyc++;

    // FIFO head and slave ready/valid driving, updated just after each edge.
    always @(posedge clk) begin
        #1;
        if (pop_seen) begin
            pop_seen = 0;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        empty = (fifo_q.size() == 0);
        line  = empty ? '0 : fifo_q[0];
        if (awvalid) begin
            awready = 1'(aw_wait >= aw_delay);
            aw_wait++;
        end else begin
            aw_wait = 0;
            awready = 1'($urandom_range(1));
        end
        if (wvalid) begin
            wready = 1'(w_wait >= w_gap);
            w_wait = wready ? 0 : w_wait + 1;
        end else begin
            w_wait = 0;
            wready = 1'($urandom_range(1));
        end
        if (bready) begin
            bvalid = 1'(b_wait >= b_delay);
            b_wait++;
        end else begin
            b_wait = 0;
            bvalid = 1'($urandom_range(1));
        end
        case ($urandom_range(2))
            0:       query_label = cur_label;
            1:       query_label = line[ENTRY_W-1 -: LABEL_WIDTH];
            default: query_label = LABEL_WIDTH'($urandom);
        endcase
    end

    // Every cycle compare the DUT against what the transaction model expects.
    always @(negedge clk) begin
        bit exp_pop;
        if (rst) begin
            check_output("rst_pop", 64'(pop), 64'd0);
            check_output("rst_busy", 64'(busy), 64'd0);
            check_output("rst_qinfl", 64'(query_inflight), 64'd0);
            check_output("rst_awvalid", 64'(awvalid), 64'd0);
            check_output("rst_wvalid", 64'(wvalid), 64'd0);
            check_output("rst_wlast", 64'(wlast), 64'd0);
            check_output("rst_bready", 64'(bready), 64'd0);
            check_output("rst_awaddr", 64'(awaddr), 64'd0);
            check_output("rst_wdata", 64'(wdata), 64'd0);
            in_flight = 0;
            aw_done   = 0;
            beats     = 0;
            cur_label = '0;
            pop_seen  = 0;
        end else begin
            exp_pop = !in_flight && !empty;
            check_output("pop", 64'(pop), 64'(exp_pop));
            check_output("busy", 64'(busy), 64'(in_flight));
            check_output("awvalid", 64'(awvalid), 64'(in_flight && !aw_done));
            check_output("wvalid", 64'(wvalid), 64'(in_flight && aw_done && beats < BEATS));
            check_output("bready", 64'(bready), 64'(in_flight && beats == BEATS));
            check_output("query_inflight", 64'(query_inflight),
                         64'(in_flight && query_label == cur_label));
            if (awvalid) begin
                check_output("awaddr", 64'(awaddr), 64'({cur_label, 5'b0}));
                check_output("awlen", 64'(awlen), 64'd7);
                check_output("awsize", 64'(awsize), 64'd2);
                check_output("awburst", 64'(awburst), 64'd1);
            end
            if (wvalid && beats < BEATS) begin
                check_output("wdata", 64'(wdata), 64'(word_of(cur_line, beats)));
                check_output("wlast", 64'(wlast), 64'(beats == BEATS - 1));
                check_output("wstrb", 64'(wstrb), 64'hF);
            end
            if (busy) busy_cycles++;
            if (awvalid || wvalid) valid_cycles++;
            if (exp_pop) begin
                cur_line  = line;
                cur_label = line[ENTRY_W-1 -: LABEL_WIDTH];
                in_flight = 1;
                aw_done   = 0;
                beats     = 0;
                pop_seen  = 1;
                pop_count++;
                pop_gap   = cyc - last_b_cyc;
            end else if (in_flight) begin
                if (!aw_done) begin
                    if (awready) begin
                        aw_done     = 1;
                        last_awaddr = awaddr;
                    end
                end else if (beats < BEATS) begin
                    if (wready) beats++;
                end else if (bvalid) begin
                    in_flight  = 0;
                    last_b_cyc = cyc;
                    lines_done++;
                end
            end
        end
    end

    initial begin
        vec_t vecs[4];
        int   p0, bc0, v0, t, n, n_push;
        entry_t e;

        rst = 1; empty = 1; line = '0; query_label = '0;
        awready = 0; wready = 0; bvalid = 0;
        vecs[0] = '{27'h0000123, 32'h000000A0, 0, 0, 32'h00002460, 10};
        vecs[1] = '{27'h7FFFFFF, 32'h11110000, 3, 1, 32'hFFFFFFE0, 21};
        vecs[2] = '{27'h0000000, 32'h22220000, 1, 2, 32'h00000000, 27};
        vecs[3] = '{27'h5555555, 32'h33330000, 2, 0, 32'hAAAAAAA0, 12};

        repeat (3) @(posedge clk);
        #2 rst = 0;
        repeat (2) @(posedge clk);

        // Single lines with varying address/data stalls.
        for (int i = 0; i < 4; i++) begin
            aw_delay = vecs[i].aw_delay;
            w_gap    = vecs[i].w_gap;
            b_delay  = 0;
            p0  = pop_count;
            bc0 = busy_cycles;
            t   = lines_done;
            apply_stimulus(make_line(vecs[i].label, vecs[i].base));
            wait_lines(t + 1, 200);
            repeat (3) @(posedge clk);
            check_output("vec_pops", 64'(pop_count - p0), 64'd1);
            check_output("vec_awaddr", 64'(last_awaddr), 64'(vecs[i].exp_addr));
            check_output("vec_busy_cycles", 64'(busy_cycles - bc0), 64'(vecs[i].exp_busy));
        end

        // Two lines queued together: second pop one cycle after the first response.
        aw_delay = 0; w_gap = 0; b_delay = 2;
        p0 = pop_count;
        t  = lines_done;
        apply_stimulus(make_line(27'h0ABCDEF, 32'h44440000));
        apply_stimulus(make_line(27'h0FEDCBA, 32'h55550000));
        wait_lines(t + 2, 300);
        repeat (2) @(posedge clk);
        check_output("b2b_pops", 64'(pop_count - p0), 64'd2);
        check_output("b2b_pop_gap", 64'(pop_gap), 64'd1);
        b_delay = 0;

        // Reset after beat 4 is accepted; the next queued line restarts cleanly.
        p0 = pop_count;
        t  = lines_done;
        apply_stimulus(make_line(27'h1234567, 32'h66660000));
        n = 0;
        while (!(in_flight && beats >= 5) && n < 50) begin
            @(posedge clk);
            n++;
        end
        check_output("mid_reach_beat5", 64'(n < 50), 64'd1);
        #2 rst = 1;
        #1;
        check_output("mid_rst_wvalid", 64'(wvalid), 64'd0);
        check_output("mid_rst_awvalid", 64'(awvalid), 64'd0);
        check_output("mid_rst_busy", 64'(busy), 64'd0);
        apply_stimulus(make_line(27'h7654321, 32'h77770000));
        repeat (2) @(posedge clk);
        #2 rst = 0;
        wait_lines(t + 1, 200);
        repeat (2) @(posedge clk);
        check_output("mid_pops", 64'(pop_count - p0), 64'd2);
        check_output("mid_fifo_drained", 64'(fifo_q.size()), 64'd0);

        // Long empty stretch: nothing may start.
        p0 = pop_count;
        v0 = valid_cycles;
        repeat (20) @(posedge clk);
        check_output("empty_pops", 64'(pop_count - p0), 64'd0);
        check_output("empty_valids", 64'(valid_cycles - v0), 64'd0);
        check_output("empty_busy", 64'(busy), 64'd0);

        // Random traffic with random slave stalls.
        t = lines_done;
        n_push = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            aw_delay = $urandom_range(3);
            w_gap    = $urandom_range(2);
            b_delay  = $urandom_range(3);
            if ($urandom_range(5) == 0 && n_push < 40) begin
                e = '0;
                for (int k = 0; k < BEATS; k++) e[k*DATA_WIDTH +: DATA_WIDTH] = $urandom;
                e[ENTRY_W-1 -: LABEL_WIDTH] = LABEL_WIDTH'($urandom);
                apply_stimulus(e);
                n_push++;
            end
        end
        wait_lines(t + n_push, 6000);
        repeat (2) @(posedge clk);
        check_output("rand_fifo_drained", 64'(fifo_q.size()), 64'd0);
        check_output("rand_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
